// File: rtl/shifter_pkg.sv
// Shared constants for the PISO shifter slice.
//   ST_IDLE / ST_SHIFT : FSM state encodings
//   DATA_W             : default parallel word width
//   state_e            : typed FSM state built on the encodings above
package shifter_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  localparam int unsigned DATA_W = 8;

  typedef enum logic {
    StIdle  = ST_IDLE,
    StShift = ST_SHIFT
  } state_e;

endpackage

// File: rtl/piso_shifter_if.sv
// Load/shift handshake bundle between a word producer and the PISO shifter.
//   en        : load strobe (producer -> shifter)
//   d         : parallel word (producer -> shifter)
//   shift_en  : advance strobe (consumer -> shifter)
//   ready     : shifter idle, a load will be accepted
//   sdo       : current serial bit, 0 when sdo_valid is low
//   sdo_valid : sdo carries a bit of the current word
//   done      : one-cycle pulse after the final bit is consumed
interface piso_shifter_if
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
);

  logic             en;
  logic [WIDTH-1:0] d;
  logic             shift_en;
  logic             ready;
  logic             sdo;
  logic             sdo_valid;
  logic             done;

  modport master (
    output en, d, shift_en,
    input  ready, sdo, sdo_valid, done
  );

  modport slave (
    input  en, d, shift_en,
    output ready, sdo, sdo_valid, done
  );

endinterface

// File: rtl/piso_shifter_bit_counter.sv
// Down-counter tracking how many bits of the current word remain on the line.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   load  : set count to MaxCount
//   dec   : decrement by one (ignored at zero, so the counter never wraps)
//   last  : count == 1, i.e. the bit now on the line is the final one
module bit_counter
  import shifter_pkg::*;
#(
  parameter int unsigned MaxCount = DATA_W,
  parameter int unsigned CntW     = $clog2(MaxCount + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic last
);

  localparam logic [CntW-1:0] LoadVal = CntW'(MaxCount);
  localparam logic [CntW-1:0] One     = CntW'(1);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LoadVal;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - One;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == One);

endmodule

// File: rtl/piso_shifter.sv
// Parallel-in/serial-out shifter: captures a word on en while idle, then
// presents it one bit at a time on sdo, advancing on each shift_en.
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   bus       : piso_shifter_if slave (en, d, shift_en in; ready, sdo,
//               sdo_valid, done out)
// Parameters: WIDTH (>= 2) word width; LSB_FIRST selects the shift direction.
// Every output is decoded from registers only.
module piso_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH     = DATA_W,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  piso_shifter_if.slave  bus
);

  // Bit presented on sdo: the end of the register the word drains from.
  localparam int unsigned OutIdx = LSB_FIRST ? 0 : WIDTH - 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             done_q, done_d;
  logic             cnt_load, cnt_dec, cnt_last;

  bit_counter #(
    .MaxCount (WIDTH)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .last  (cnt_last)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      shreg_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.en) begin
          shreg_d  = bus.d;
          cnt_load = 1'b1;
          state_d  = StShift;
        end
      end
      StShift: begin
        // en/d are deliberately ignored here: a word is never aborted.
        if (bus.shift_en) begin
          cnt_dec = 1'b1;
          shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
          if (cnt_last) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    bus.ready     = (state_q == StIdle);
    bus.sdo_valid = (state_q == StShift);
    bus.sdo       = (state_q == StShift) ? shreg_q[OutIdx] : 1'b0;
    bus.done      = done_q;
  end

endmodule

// File: tb/tb_piso_shifter.sv
// Self-checking bench for piso_shifter: one LSB-first and one MSB-first
// instance receive identical stimulus; a per-instance queue of expected bits
// is filled when a load is accepted and drained as shift steps are accepted.
module tb_piso_shifter;

  localparam int unsigned W = 8;

  logic         clk;
  logic         reset;
  logic         en;
  logic [W-1:0] d;
  logic         shift_en;

  piso_shifter_if #(.WIDTH(W)) bus_l ();
  piso_shifter_if #(.WIDTH(W)) bus_m ();

  assign bus_l.en       = en;
  assign bus_l.d        = d;
  assign bus_l.shift_en = shift_en;
  assign bus_m.en       = en;
  assign bus_m.d        = d;
  assign bus_m.shift_en = shift_en;

  piso_shifter #(.WIDTH(W), .LSB_FIRST(1'b1)) u_dut_lsb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_l)
  );

  piso_shifter #(.WIDTH(W), .LSB_FIRST(1'b0)) u_dut_msb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: index 0 = LSB-first instance, 1 = MSB-first instance.
  bit exp_q [2][$];
  bit exp_done [2];

  always @(negedge clk) begin
    logic  rdy, vld, s, dn;
    string p;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        rdy = bus_l.ready; vld = bus_l.sdo_valid; s = bus_l.sdo; dn = bus_l.done; p = "lsb";
      end else begin
        rdy = bus_m.ready; vld = bus_m.sdo_valid; s = bus_m.sdo; dn = bus_m.done; p = "msb";
      end
      if (!reset) begin
        check({p, "_rst_ready"}, {31'd0, rdy}, 32'd1);
        check({p, "_rst_valid"}, {31'd0, vld}, 32'd0);
        check({p, "_rst_sdo"},   {31'd0, s},   32'd0);
        check({p, "_rst_done"},  {31'd0, dn},  32'd0);
        exp_q[i].delete();
        exp_done[i] = 1'b0;
      end else begin
        check({p, "_ready"}, {31'd0, rdy}, {31'd0, exp_q[i].size() == 0});
        check({p, "_valid"}, {31'd0, vld}, {31'd0, exp_q[i].size() != 0});
        check({p, "_done"},  {31'd0, dn},  {31'd0, exp_done[i]});
        check({p, "_sdo"},   {31'd0, s},   {31'd0, (exp_q[i].size() != 0) ? exp_q[i][0] : 1'b0});
        exp_done[i] = 1'b0;
        if (exp_q[i].size() != 0) begin
          if (shift_en) begin
            void'(exp_q[i].pop_front());
            if (exp_q[i].size() == 0) exp_done[i] = 1'b1;
          end
        end else if (en) begin
          for (int b = 0; b < int'(W); b++) begin
            exp_q[i].push_back(d[(i == 0) ? b : int'(W) - 1 - b]);
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, n < 100}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [W-1:0] word);
    en = 1'b1;
    d  = word;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  initial begin
    bit pat [10] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};

    // Reset held with a load request present: nothing may be captured.
    reset    = 1'b0;
    en       = 1'b1;
    d        = 8'hFF;
    shift_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Continuous shifting of 8'h0F.
    shift_en = 1'b1;
    load_word(8'h0F);
    wait_idle();

    // Irregular shift_en pacing on 8'hC0.
    shift_en = 1'b0;
    load_word(8'hC0);
    for (int k = 0; k < 10; k++) begin
      shift_en = pat[k];
      @(posedge clk);
      #1;
    end
    shift_en = 1'b1;
    wait_idle();

    // Load attempt in the 3rd SHIFT cycle must be ignored.
    load_word(8'hA5);
    @(posedge clk);
    #1;
    en = 1'b1;
    d  = 8'hF0;
    @(posedge clk);
    #1;
    en = 1'b0;
    wait_idle();

    // Reset asserted after 3 bits of 8'h3C; word discarded at once.
    load_word(8'h3C);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("async_rst_lsb_ready", {31'd0, bus_l.ready},     32'd1);
    check("async_rst_lsb_valid", {31'd0, bus_l.sdo_valid}, 32'd0);
    check("async_rst_msb_ready", {31'd0, bus_m.ready},     32'd1);
    check("async_rst_msb_valid", {31'd0, bus_m.sdo_valid}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    load_word(8'h0F);
    wait_idle();

    // Back-to-back: second load presented during the done cycle.
    load_word(8'h81);
    repeat (8) @(posedge clk);
    #1;
    check("b2b_lsb_done", {31'd0, bus_l.done},  32'd1);
    check("b2b_lsb_ready", {31'd0, bus_l.ready}, 32'd1);
    load_word(8'h7E);
    check("b2b_lsb_valid2", {31'd0, bus_l.sdo_valid}, 32'd1);
    check("b2b_msb_valid2", {31'd0, bus_m.sdo_valid}, 32'd1);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/piso_shifter.md
Name: piso_shifter

Overview:
- Parallel-in/serial-out shifter: the read-out end of the 8-bit enabled register path. It takes a registered parallel word and emits it one bit per accepted shift step.
- Loads a word on the `en` strobe, then drives it out on `sdo` under `shift_en` pacing.
- Reports `ready` when idle and pulses `done` after the last bit.
- Sits between the register stage and any downstream serial consumer.

Parameters:
- WIDTH, 8, word width in bits; must be >= 2.
- LSB_FIRST, 1, 1 = bit 0 shifted first; 0 = bit WIDTH-1 shifted first.

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- en  in  1  load strobe; sampled only when ready=1.
- d  in  WIDTH  parallel word to load.
- shift_en  in  1  advance-to-next-bit strobe; sampled only in SHIFT.
- ready  out  1  1 = idle, a load will be accepted.
- sdo  out  1  current serial bit; 0 when sdo_valid=0.
- sdo_valid  out  1  1 = sdo holds a valid bit of the current word.
- done  out  1  one-cycle pulse after the final bit is consumed.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, shift register=0, bit count=0, ready=1, sdo=0, sdo_valid=0, done=0. Release is synchronous to the next clk edge.
- All outputs are decoded from registers only; there is no combinational path from any input to any output.
- States: IDLE, SHIFT.
- IDLE:
  - ready=1, sdo_valid=0.
  - Edge with en=1: capture d, set count=WIDTH, go to SHIFT.
  - Edge with en=0: stay in IDLE.
  - shift_en is ignored.
- SHIFT:
  - ready=0, sdo_valid=1.
  - sdo = shreg[0] when LSB_FIRST=1, else shreg[WIDTH-1].
  - Edge with shift_en=1: shift one position (zero fill), count -= 1.
  - Edge with shift_en=1 and count==1: go to IDLE and assert done=1 for exactly the next cycle.
  - Edge with shift_en=0: hold all state; the same bit remains on sdo.
  - en and d are ignored; no reload or abort occurs mid-word.
- Latency:
  - en accepted at edge k: the first bit is on sdo with sdo_valid=1 after edge k.
  - With shift_en held at 1, the last bit is present after edge k+WIDTH-1.
  - After edge k+WIDTH: done=1, ready=1, sdo_valid=0.
- Back-to-back: in the done=1 cycle, ready=1 too. en=1 at the following edge loads the next word, giving zero idle cycles beyond the done cycle.
- Counter width is $clog2(WIDTH+1). The counter never wraps: it is only decremented in SHIFT while count>=1.
- Reset asserted mid-word: the word is discarded immediately (asynchronously). There is no done pulse and outputs go to their reset values.
- done is never asserted in the same cycle as sdo_valid.

Decomposition:
- Shared package (shifter_pkg) holds:
  - state encoding constants ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - default width constant DATA_W=8.
- One natural sub-module: bit_counter.
  - Parameterised down-counter with load, decrement-enable and terminal (count==1) flag.
  - Asynchronous active-low reset.
- The shift register and FSM stay in the top module.

Test Plan:
1. Reset: hold reset=0 for 2 cycles with en=1 and d=8'hFF -> ready=1, sdo_valid=0, sdo=0, done=0. Nothing is loaded.
2. LSB_FIRST=1, d=8'b0000_1111, en pulsed once, shift_en=1 -> sdo sequence 1,1,1,1,0,0,0,0 over 8 cycles, then done=1 for one cycle and ready=1.
3. LSB_FIRST=0, d=8'b1100_0000, shift_en pattern 1,0,1,1,0,1,1,1,1,1 -> sdo sequence 1,1(held),1,0,0(held),0,0,0,0,0. done fires after the 8th accepted shift.
4. en=1 with d=8'b1111_0000 in the 3rd cycle of SHIFT while word 8'hA5 is in flight -> output is still the full 8'hA5 bits (LSB-first 1,0,1,0,0,1,0,1). The second word is never emitted.
5. reset=0 asserted after 3 bits of 8'h3C, then released -> sdo_valid=0 and ready=1 immediately, no done pulse. A next load of 8'h0F shifts out cleanly.
6. Back-to-back: load 8'h81 then 8'h7E with en=1 in the done cycle's following edge, shift_en=1 throughout -> 16 valid bits with exactly one sdo_valid=0 cycle (the done cycle) between words.
